cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits directly downstream of the L1 cache datapath, on its pmem side.
- Converts one 256-bit line transaction (pmem_rdata / pmem_wdata / pmem_address / read / write / resp) into a 4-beat × 64-bit burst on the physical memory bus.
- Assembles read bursts into a full line and serialises write-back lines into beats.
- Exactly one transaction in flight at a time.

Parameters:
- LINE_WIDTH, 256, cache line width in bits; must equal BURST_WIDTH*BEATS.
- BURST_WIDTH, 64, memory bus beat width in bits.
- BEATS, 4, beats per line; derived constant LINE_WIDTH/BURST_WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- line_i  input  256  write-back line from cache (pmem_wdata).
- line_o  output  256  assembled read line to cache (pmem_rdata).
- address_i  input  32  line address from cache (pmem_address).
- read_i  input  1  line read request, held until resp_o.
- write_i  input  1  line write request, held until resp_o.
- resp_o  output  1  one-cycle transaction-complete pulse.
- burst_i  input  64  read beat from memory.
- burst_o  output  64  write beat to memory.
- address_o  output  32  line-aligned burst address to memory.
- read_o  output  1  burst read request.
- write_o  output  1  burst write request.
- resp_i  input  1  per-beat acknowledge from memory.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset values: state IDLE, beat count 0, all outputs 0 (line_o, burst_o, address_o, read_o, write_o, resp_o).
- States: IDLE, RD, WR, DONE.
- IDLE accept:
  - write_i=1 → WR; write has priority when read_i and write_i are both high (dirty eviction first).
  - Else read_i=1 → RD.
  - On accept, latch address_i as {address_i[31:5],5'b0}, latch line_i (write only), clear beat count.
- RD:
  - read_o=1 from the first cycle after accept.
  - Each cycle with resp_i=1: burst_i written to line_o slice [64*cnt+63 : 64*cnt], cnt++.
  - Beats may be non-consecutive; resp_i=0 cycles hold state.
  - The 4th beat goes to DONE; read_o drops in that same next cycle.
- WR:
  - write_o=1; burst_o = latched line slice [64*cnt+63 : 64*cnt], combinationally from cnt.
  - Each resp_i=1 advances cnt.
  - The 4th ack goes to DONE; write_o drops.
- DONE:
  - resp_o=1 for exactly one cycle, then → IDLE.
  - read_o=write_o=0.
- read_i/write_i are ignored outside IDLE. The requester must drop its request in the cycle after resp_o; any request seen in IDLE starts a new transaction.
- line_o holds the last completed read line until the next read beat 0 overwrites slice 0. Partial lines are visible mid-read; the cache samples line_o only on resp_o.
- address_o stays stable for the whole transaction and holds its value in IDLE.
- resp_i in IDLE or DONE is ignored; no state change.
- cnt is 2 bits and wraps 3→0 only on the final beat, simultaneous with the transition to DONE.
- Latency: read_i accept at edge t, read_o high in cycle t+1. With back-to-back acks, beats arrive t+1..t+4 and resp_o is high in cycle t+5. Writes have the same timing.
- Reset mid-transaction: next cycle state=IDLE, read_o/write_o/resp_o=0, cnt=0, line_o=0; no partial line is reported.
- Illegal: address_i, read_i, write_i or line_i changing while a request is held. The latched copies are used; the bench asserts this never happens.

Test Plan:
- Read, back-to-back beats: address_i=0x1234_5678, read_i=1; memory returns beats 0x00..00, 0x11..11, 0x22..22, 0x33..33 on resp_i cycles 1-4 → address_o=0x1234_5660, read_o high 4 cycles, resp_o one pulse at cycle 5, line_o=0x33..33_22..22_11..11_00..00.
- Write: line_i = {64'hD,64'hC,64'hB,64'hA}, write_i=1, resp_i acks every other cycle → burst_o sequence A,B,C,D each held until its ack, write_o high 8 cycles, single resp_o, address aligned.
- Simultaneous read_i=write_i=1 → WR entered first, write_o=1, read_o=0; after resp_o, with read_i still high and write_i low, a read starts.
- Spurious resp_i in IDLE for 3 cycles → no state change, resp_o=0, line_o unchanged.
- Reset asserted after 2 read beats → next cycle read_o=0, line_o=0, resp_o never pulses; a fresh read then completes normally with correct beat order.
- Back-to-back transactions: write then read with no idle gap besides DONE → each gets exactly one resp_o; read data is unaffected by the prior write beats.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Bridges the L1 cache pmem side to a narrow burst memory bus. A single
//   LINE_WIDTH line transaction becomes BEATS beats of BURST_WIDTH bits.
//   Read bursts are assembled into line_o. Write-back lines are latched
//   and serialised onto burst_o. Only one transaction is in flight.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   line_i       : write-back line from cache
//   line_o       : assembled read line to cache (valid when resp_o pulses)
//   address_i    : line address from cache
//   read_i       : line read request, held until resp_o
//   write_i      : line write request, held until resp_o
//   resp_o       : one-cycle transaction-complete pulse
//   burst_i      : read beat from memory
//   burst_o      : write beat to memory
//   address_o    : line-aligned burst address to memory
//   read_o       : burst read request
//   write_o      : burst write request
//   resp_i       : per-beat acknowledge from memory
module cacheline_adaptor #(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned BURST_WIDTH = 64,
  parameter int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [31:0]            address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [31:0]            address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int unsigned     CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
  // Byte-offset bits inside one line; cleared to line-align the address.
  localparam logic [31:0]     OFFSET_MASK = 32'(LINE_WIDTH / 8 - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [LINE_WIDTH-1:0]   line_buf;

  // The write beat follows the beat counter directly so the next beat is
  // presented in the same cycle the counter advances.
  always_comb begin
    burst_o = line_buf[BURST_WIDTH*cnt +: BURST_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      line_buf  <= '0;
      line_o    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      unique case (state)
        IDLE: begin
          // Write first: a dirty eviction must reach memory before the
          // refill read of the same request pair.
          if (write_i) begin
            state     <= WR;
            write_o   <= 1'b1;
            address_o <= address_i & ~OFFSET_MASK;
            line_buf  <= line_i;
            cnt       <= '0;
          end else if (read_i) begin
            state     <= RD;
            read_o    <= 1'b1;
            address_o <= address_i & ~OFFSET_MASK;
            cnt       <= '0;
          end
        end

        RD: begin
          if (resp_i) begin
            line_o[BURST_WIDTH*cnt +: BURST_WIDTH] <= burst_i;
            if (cnt == LAST_BEAT) begin
              cnt    <= '0;
              state  <= DONE;
              read_o <= 1'b0;
              resp_o <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        WR: begin
          if (resp_i) begin
            if (cnt == LAST_BEAT) begin
              cnt     <= '0;
              state   <= DONE;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          read_o  <= 1'b0;
          write_o <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor. A small memory responder acks
// beats with a configurable period; expected lines, beats and addresses are
// queued when a request is issued and checked when the DUT produces them.
module tb_cacheline_adaptor;

  localparam int LW = 256;
  localparam int BW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] line_i;
  logic [LW-1:0] line_o;
  logic [31:0]   address_i;
  logic          read_i;
  logic          write_i;
  logic          resp_o;
  logic [BW-1:0] burst_i;
  logic [BW-1:0] burst_o;
  logic [31:0]   address_o;
  logic          read_o;
  logic          write_o;
  logic          resp_i;

  int checks = 0;
  int errors = 0;

  logic [LW-1:0] line_q[$];
  logic [BW-1:0] beat_q[$];
  logic [BW-1:0] mem_q[$];
  logic [31:0]   addr_q[$];

  cacheline_adaptor #(
    .LINE_WIDTH (LW),
    .BURST_WIDTH(BW),
    .BEATS      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .line_i   (line_i),
    .line_o   (line_o),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .resp_o   (resp_o),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .resp_i   (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_read(input logic [31:0] addr, input logic [BW-1:0] b0,
                            input logic [BW-1:0] b1, input logic [BW-1:0] b2,
                            input logic [BW-1:0] b3);
    mem_q.push_back(b0);
    mem_q.push_back(b1);
    mem_q.push_back(b2);
    mem_q.push_back(b3);
    line_q.push_back({b3, b2, b1, b0});
    addr_q.push_back({addr[31:5], 5'b0});
    address_i = addr;
    read_i    = 1'b1;
  endtask

  task automatic issue_write(input logic [31:0] addr, input logic [LW-1:0] line);
    for (int i = 0; i < 4; i++) beat_q.push_back(line[i*BW +: BW]);
    addr_q.push_back({addr[31:5], 5'b0});
    address_i = addr;
    line_i    = line;
    write_i   = 1'b1;
  endtask

  // Runs one transaction to its resp_o cycle and returns there (requests
  // dropped during the resp_o cycle). exp_at is the cycle index of resp_o
  // counted from the first edge after the call.
  task automatic service(input bit is_read, input int period, input int exp_at,
                         input int exp_active, input string tag);
    int rd_cyc = 0;
    int wr_cyc = 0;
    int phase = 0;
    int resp_at = -1;
    for (int c = 0; c < 64 && resp_at < 0; c++) begin
      @(posedge clk); #1;
      resp_i = 1'b0;
      if (read_o) rd_cyc++;
      if (write_o) wr_cyc++;
      if (write_o && beat_q.size() > 0) chk({tag, " burst_o"}, burst_o, beat_q[0]);
      if ((read_o || write_o) && addr_q.size() > 0) chk({tag, " address_o"}, address_o, addr_q[0]);
      if (read_o || write_o) begin
        if (phase % period == period - 1) begin
          resp_i = 1'b1;
          if (read_o && mem_q.size() > 0) burst_i = mem_q.pop_front();
          else burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
          if (write_o && beat_q.size() > 0) beat_q.delete(0);
        end
        phase++;
      end
      if (resp_o) begin
        resp_at = c;
        if (is_read) begin
          read_i = 1'b0;
          if (line_q.size() > 0) chk({tag, " line_o"}, line_o, line_q.pop_front());
        end else begin
          write_i = 1'b0;
        end
        if (addr_q.size() > 0) chk({tag, " resp address_o"}, address_o, addr_q.pop_front());
      end
    end
    resp_i = 1'b0;
    if (resp_at < 0) chk({tag, " timeout"}, 0, 1);
    else chk({tag, " resp cycle"}, 32'(resp_at), 32'(exp_at));
    chk({tag, " read_o cycles"}, 32'(rd_cyc), is_read ? 32'(exp_active) : 32'd0);
    chk({tag, " write_o cycles"}, 32'(wr_cyc), is_read ? 32'd0 : 32'(exp_active));
  endtask

  initial begin
    logic [LW-1:0] held;
    int            pulses;

    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst line_o", line_o, '0);
    chk("rst burst_o", burst_o, '0);
    chk("rst address_o", address_o, '0);
    chk("rst read_o", read_o, 0);
    chk("rst write_o", write_o, 0);
    chk("rst resp_o", resp_o, 0);
    rst = 1'b0;

    // Read, back-to-back beats.
    issue_read(32'h1234_5678, 64'h0000_0000_0000_0000, 64'h1111_1111_1111_1111,
               64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333);
    service(1'b1, 1, 4, 4, "rd_b2b");
    @(posedge clk); #1;
    chk("after rd resp_o low", resp_o, 0);

    // Write with acks every other cycle.
    issue_write(32'hABCD_EF1F, {64'hD, 64'hC, 64'hB, 64'hA});
    service(1'b0, 2, 8, 8, "wr_slow");
    @(posedge clk); #1;

    // Simultaneous read and write: write first, then the held read.
    issue_write(32'h0000_8040, {64'h4444_0004, 64'h4444_0003, 64'h4444_0002, 64'h4444_0001});
    read_i = 1'b1;
    service(1'b0, 1, 4, 4, "both_wr");
    issue_read(32'h0000_8040, 64'h5555_0001, 64'h5555_0002, 64'h5555_0003, 64'h5555_0004);
    service(1'b1, 1, 5, 4, "both_rd");
    @(posedge clk); #1;

    // Spurious acks in IDLE.
    held = line_o;
    resp_i = 1'b1;
    burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("spur resp_o", resp_o, 0);
      chk("spur read_o", read_o, 0);
      chk("spur write_o", write_o, 0);
      chk("spur line_o", line_o, held);
    end
    resp_i = 1'b0;

    // Reset after two read beats.
    address_i = 32'h0000_1040;
    read_i = 1'b1;
    @(posedge clk); #1;
    chk("mid read_o", read_o, 1);
    resp_i = 1'b1; burst_i = 64'h6666_0000_0000_0000;
    @(posedge clk); #1;
    burst_i = 64'h6666_1111_1111_1111;
    @(posedge clk); #1;
    chk("mid partial line", line_o[127:0], {64'h6666_1111_1111_1111, 64'h6666_0000_0000_0000});
    resp_i = 1'b0; read_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid rst read_o", read_o, 0);
    chk("mid rst line_o", line_o, '0);
    chk("mid rst resp_o", resp_o, 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (resp_o) pulses++;
    end
    chk("mid rst no resp", 32'(pulses), 32'd0);
    issue_read(32'h0000_1044, 64'h7777_0000, 64'h7777_1111, 64'h7777_2222, 64'h7777_3333);
    service(1'b1, 1, 4, 4, "rd_after_rst");
    @(posedge clk); #1;

    // Write immediately followed by a read.
    issue_write(32'h00FF_0020, {64'h8888_0004, 64'h8888_0003, 64'h8888_0002, 64'h8888_0001});
    service(1'b0, 1, 4, 4, "b2b_wr");
    issue_read(32'h00FF_0020, 64'h9999_0001, 64'h9999_0002, 64'h9999_0003, 64'h9999_0004);
    service(1'b1, 1, 5, 4, "b2b_rd");
    @(posedge clk); #1;
    chk("end resp_o", resp_o, 0);
    chk("end address hold", address_o, 32'h00FF_0020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
